// File: rtl/ram_port_arbiter_if.sv
// Channel-side bus of the RAM port arbiter: packed per-channel requests in,
// one-hot grants and shared read-return bus out.
interface ram_port_arbiter_if #(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 16
) ();
  logic [NUM_CH-1:0]        req;
  logic [NUM_CH-1:0]        we;
  logic [NUM_CH*ADDR_W-1:0] addr;
  logic [NUM_CH*DATA_W-1:0] wdata;
  logic [NUM_CH-1:0]        gnt;
  logic [NUM_CH-1:0]        rvalid;
  logic [DATA_W-1:0]        rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// N-channel arbiter onto one RAM port: starvation override, optional fixed priority
// for channel 0, round-robin for the rest, tagged in-order read return.
module ram_port_arbiter #(
  parameter int unsigned NUM_CH   = 3,
  parameter int unsigned ADDR_W   = 15,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned PRIO0    = 1,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  ram_port_arbiter_if.slave bus,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout
);
  localparam int unsigned PtrW = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CntW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_WAIT);

  typedef struct packed {
    logic            vld;
    logic [PtrW-1:0] ch;
  } tag_t;

  logic [PtrW-1:0]   rr_q;
  logic [CntW-1:0]   wait_q [NUM_CH];
  tag_t              tag_q [RD_LAT];
  logic [NUM_CH-1:0] rvalid_q;

  logic              found;
  logic              upd_rr;
  logic [PtrW-1:0]   sel;
  logic [PtrW-1:0]   cand;
  logic [NUM_CH-1:0] gnt;

  always_comb begin
    found  = 1'b0;
    upd_rr = 1'b0;
    sel    = '0;
    cand   = '0;
    if (PRIO0 != 0) begin
      // Starved channels beat channel 0; lowest index first.
      for (int i = 1; i < NUM_CH; i++) begin
        if (!found && bus.req[i] && (wait_q[i] == CntMax)) begin
          found  = 1'b1;
          upd_rr = 1'b1;
          sel    = PtrW'(i);
        end
      end
      if (!found && bus.req[0]) begin
        found = 1'b1;
        sel   = '0;
      end
    end
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      cand = PtrW'((32'(rr_q) + k) % NUM_CH);
      if (!found && bus.req[cand]) begin
        found  = 1'b1;
        upd_rr = 1'b1;
        sel    = cand;
      end
    end
  end

  assign gnt        = found ? (NUM_CH'(1) << sel) : '0;
  assign bus.gnt    = gnt;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = (|rvalid_q) ? ram_dout : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q     <= PtrW'(NUM_CH - 1);
      ram_addr <= '0;
      ram_din  <= '0;
      ram_we   <= 1'b0;
      rvalid_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        wait_q[i] <= '0;
      end
      for (int k = 0; k < RD_LAT; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      if (found && upd_rr) begin
        rr_q <= sel;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (!bus.req[i] || gnt[i]) begin
          wait_q[i] <= '0;
        end else if (wait_q[i] != CntMax) begin
          wait_q[i] <= wait_q[i] + CntW'(1);
        end
      end
      ram_we <= found & bus.we[sel];
      if (found) begin
        ram_addr <= bus.addr[sel*ADDR_W +: ADDR_W];
        ram_din  <= bus.wdata[sel*DATA_W +: DATA_W];
      end
      // Tag stages track the RAM latency so rvalid lines up with ram_dout.
      tag_q[0].vld <= found & ~bus.we[sel];
      tag_q[0].ch  <= sel;
      for (int k = 1; k < RD_LAT; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
      rvalid_q <= tag_q[RD_LAT-1].vld ? (NUM_CH'(1) << tag_q[RD_LAT-1].ch) : '0;
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: two configurations (RD_LAT=1 with priority and
// MAX_WAIT=3; RD_LAT=3 pure round-robin) checked against a rule-level model.
module tb_ram_port_arbiter;
  localparam int NCH = 3;
  localparam int AW  = 15;
  localparam int DW  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_port_arbiter_if #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW)) ifa ();
  ram_port_arbiter_if #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW)) ifb ();

  logic [NCH-1:0]    req_v   [2];
  logic [NCH-1:0]    we_v    [2];
  logic [NCH*AW-1:0] addr_v  [2];
  logic [NCH*DW-1:0] wd_v    [2];
  logic [NCH-1:0]    gnt_s   [2];
  logic [NCH-1:0]    rvalid_s[2];
  logic [DW-1:0]     rdata_s [2];
  logic [AW-1:0]     ram_addr_s[2];
  logic [DW-1:0]     ram_din_s [2];
  logic [DW-1:0]     ram_dout_s[2];
  logic              ram_we_s  [2];

  assign ifa.req = req_v[0];  assign ifa.we = we_v[0];
  assign ifa.addr = addr_v[0]; assign ifa.wdata = wd_v[0];
  assign ifb.req = req_v[1];  assign ifb.we = we_v[1];
  assign ifb.addr = addr_v[1]; assign ifb.wdata = wd_v[1];
  assign gnt_s[0] = ifa.gnt;  assign rvalid_s[0] = ifa.rvalid; assign rdata_s[0] = ifa.rdata;
  assign gnt_s[1] = ifb.gnt;  assign rvalid_s[1] = ifb.rvalid; assign rdata_s[1] = ifb.rdata;

  ram_port_arbiter #(
    .NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .PRIO0(1), .MAX_WAIT(3)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa),
    .ram_addr(ram_addr_s[0]), .ram_din(ram_din_s[0]), .ram_we(ram_we_s[0]),
    .ram_dout(ram_dout_s[0])
  );

  ram_port_arbiter #(
    .NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .PRIO0(0), .MAX_WAIT(15)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb),
    .ram_addr(ram_addr_s[1]), .ram_din(ram_din_s[1]), .ram_we(ram_we_s[1]),
    .ram_dout(ram_dout_s[1])
  );

  function automatic int lat_of(input int d);  return (d == 0) ? 1 : 3;  endfunction
  function automatic bit prio_of(input int d); return (d == 0);          endfunction
  function automatic int maxw_of(input int d); return (d == 0) ? 3 : 15; endfunction

  // RAM models: address registered, data appears RD_LAT cycles later.
  logic [DW-1:0] ram_mem [2][32768];
  logic [DW-1:0] dpipe   [2][4];
  assign ram_dout_s[0] = dpipe[0][0];
  assign ram_dout_s[1] = dpipe[1][2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 32768; a++) ram_mem[d][a] = 16'(a) ^ 16'h5A5A;
      for (int k = 0; k < 4; k++) dpipe[d][k] = '0;
    end
    ram_mem[0][15'h0123] = 16'hBEEF;
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        for (int k = 3; k > 0; k--) dpipe[d][k] = dpipe[d][k-1];
        dpipe[d][0] = ram_mem[d][ram_addr_s[d]];
        if (ram_we_s[d]) ram_mem[d][ram_addr_s[d]] = ram_din_s[d];
      end
    end
  end

  int total = 0;
  int bad = 0;
  int cyc = 0;

  task automatic chk(input int d, input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL dut%0d %s cyc=%0d got=%0h want=%0h", d, nm, cyc, act, exp);
    end
  endtask

  // Model state: last round-robin winner, consecutive-denial counts, shadow memory,
  // and a time-slot scoreboard of expected read returns.
  int            rr_m    [2];
  int            wcnt_m  [2][NCH];
  logic [DW-1:0] shadow  [2][32768];
  int            slot_ch [2][16];
  logic [DW-1:0] slot_dat[2][16];
  logic [AW-1:0] e_addr  [2];
  logic [DW-1:0] e_din   [2];
  logic          e_we    [2];

  function automatic void pick(input int d, input logic [NCH-1:0] r,
                               output int w, output bit by_prio);
    w = -1;
    by_prio = 1'b0;
    if (prio_of(d)) begin
      for (int i = 1; i < NCH; i++)
        if (w < 0 && r[i] && wcnt_m[d][i] == maxw_of(d)) w = i;
      if (w < 0 && r[0]) begin
        w = 0;
        by_prio = 1'b1;
      end
    end
    for (int k = 1; k <= NCH; k++)
      if (w < 0 && r[(rr_m[d] + k) % NCH]) w = (rr_m[d] + k) % NCH;
  endfunction

  initial begin : cmp
    int w;
    int s;
    bit pw;
    logic [AW-1:0] a;
    for (int d = 0; d < 2; d++) begin
      for (int x = 0; x < 32768; x++) shadow[d][x] = 16'(x) ^ 16'h5A5A;
      for (int k = 0; k < 16; k++) slot_ch[d][k] = -1;
      rr_m[d] = NCH - 1;
      for (int i = 0; i < NCH; i++) wcnt_m[d][i] = 0;
      e_addr[d] = '0; e_din[d] = '0; e_we[d] = 1'b0;
    end
    shadow[0][15'h0123] = 16'hBEEF;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!rst_n) begin
          rr_m[d] = NCH - 1;
          for (int i = 0; i < NCH; i++) wcnt_m[d][i] = 0;
          for (int k = 0; k < 16; k++) slot_ch[d][k] = -1;
          e_addr[d] = '0; e_din[d] = '0; e_we[d] = 1'b0;
        end
        s = cyc % 16;
        chk(d, "ram_we", 32'(ram_we_s[d]), 32'(e_we[d]));
        chk(d, "ram_addr", 32'(ram_addr_s[d]), 32'(e_addr[d]));
        chk(d, "ram_din", 32'(ram_din_s[d]), 32'(e_din[d]));
        chk(d, "rvalid", 32'(rvalid_s[d]),
            (slot_ch[d][s] >= 0) ? (32'd1 << slot_ch[d][s]) : 32'd0);
        if (slot_ch[d][s] >= 0) chk(d, "rdata", 32'(rdata_s[d]), 32'(slot_dat[d][s]));
        slot_ch[d][s] = -1;
        pick(d, req_v[d], w, pw);
        chk(d, "gnt", 32'(gnt_s[d]), (w >= 0) ? (32'd1 << w) : 32'd0);
        if (rst_n) begin
          for (int i = 0; i < NCH; i++) begin
            if (!req_v[d][i] || i == w) wcnt_m[d][i] = 0;
            else if (wcnt_m[d][i] < maxw_of(d)) wcnt_m[d][i]++;
          end
          if (w >= 0 && !pw) rr_m[d] = w;
          if (w >= 0) begin
            a = addr_v[d][w*AW +: AW];
            e_addr[d] = a;
            e_din[d] = wd_v[d][w*DW +: DW];
            e_we[d] = we_v[d][w];
            if (we_v[d][w]) begin
              shadow[d][a] = e_din[d];
            end else begin
              slot_ch[d][(cyc + 1 + lat_of(d)) % 16] = w;
              slot_dat[d][(cyc + 1 + lat_of(d)) % 16] = shadow[d][a];
            end
          end else begin
            e_we[d] = 1'b0;
          end
        end
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int d, input int ch, input logic r, input logic w,
                        input logic [AW-1:0] a, input logic [DW-1:0] wd);
    req_v[d][ch] = r;
    we_v[d][ch] = w;
    addr_v[d][ch*AW +: AW] = a;
    wd_v[d][ch*DW +: DW] = wd;
  endtask

  task automatic clr(input int d);
    req_v[d] = '0;
    we_v[d] = '0;
  endtask

  logic [NCH-1:0] star_exp [8];
  int nret;

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_v[d] = '0; we_v[d] = '0; addr_v[d] = '0; wd_v[d] = '0;
    end
    star_exp[0] = 3'b001; star_exp[1] = 3'b001; star_exp[2] = 3'b001; star_exp[3] = 3'b010;
    star_exp[4] = 3'b001; star_exp[5] = 3'b001; star_exp[6] = 3'b001; star_exp[7] = 3'b010;
    rst_n = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk(0, "rst_ram_we", 32'(ram_we_s[0]), 32'd0);
    chk(0, "rst_rvalid", 32'(rvalid_s[0]), 32'd0);
    chk(0, "rst_rdata", 32'(rdata_s[0]), 32'd0);
    tick();
    rst_n = 1'b1;

    // Single read: grant at t, address at t+1, data at t+2.
    tick(); set_ch(0, 2, 1'b1, 1'b0, 15'h0123, '0);
    @(negedge clk); chk(0, "sr_gnt", 32'(gnt_s[0]), 32'b100);
    tick(); clr(0);
    @(negedge clk); chk(0, "sr_addr", 32'(ram_addr_s[0]), 32'h0123);
    tick();
    @(negedge clk); chk(0, "sr_rvalid", 32'(rvalid_s[0]), 32'b100);
    chk(0, "sr_rdata", 32'(rdata_s[0]), 32'hBEEF);

    // Write then read of the same address, back to back.
    tick(); set_ch(0, 0, 1'b1, 1'b1, 15'h0005, 16'h1234);
    tick(); clr(0); set_ch(0, 1, 1'b1, 1'b0, 15'h0005, '0);
    @(negedge clk); chk(0, "b2b_we1", 32'(ram_we_s[0]), 32'd1);
    tick(); clr(0);
    @(negedge clk); chk(0, "b2b_we0", 32'(ram_we_s[0]), 32'd0);
    tick();
    @(negedge clk); chk(0, "b2b_rvalid", 32'(rvalid_s[0]), 32'b010);
    chk(0, "b2b_rdata", 32'(rdata_s[0]), 32'h1234);

    // Priority vs starvation with MAX_WAIT=3, then two channels starving together.
    tick(); set_ch(0, 0, 1'b1, 1'b0, 15'h0010, '0); set_ch(0, 1, 1'b1, 1'b0, 15'h0020, '0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      @(negedge clk); chk(0, "starve_gnt", 32'(gnt_s[0]), 32'(star_exp[i]));
    end
    for (int i = 8; i < 14; i++) begin
      tick();
      if (i == 8) set_ch(0, 2, 1'b1, 1'b0, 15'h0030, '0);
      @(negedge clk);
      if (i == 11) chk(0, "dual_starve1", 32'(gnt_s[0]), 32'b010);
      if (i == 12) chk(0, "dual_starve2", 32'(gnt_s[0]), 32'b100);
    end
    tick(); clr(0);

    // Reset one cycle after a read grant: the read must never return.
    tick(); set_ch(0, 1, 1'b1, 1'b0, 15'h0010, '0);
    @(negedge clk); chk(0, "mr_gnt", 32'(gnt_s[0]), 32'b010);
    tick(); clr(0); rst_n = 1'b0;
    @(negedge clk);
    chk(0, "mr_ram_we", 32'(ram_we_s[0]), 32'd0);
    chk(0, "mr_ram_addr", 32'(ram_addr_s[0]), 32'd0);
    chk(0, "mr_rvalid", 32'(rvalid_s[0]), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) rst_n = 1'b1;
      @(negedge clk); chk(0, "mr_no_rvalid", 32'(rvalid_s[0]), 32'd0);
    end

    // Round-robin from reset on the PRIO0=0 instance.
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) begin
        set_ch(1, 0, 1'b1, 1'b0, 15'h0100, '0);
        set_ch(1, 1, 1'b1, 1'b0, 15'h0200, '0);
        set_ch(1, 2, 1'b1, 1'b0, 15'h0300, '0);
      end
      @(negedge clk); chk(1, "rr_gnt", 32'(gnt_s[1]), 32'd1 << (i % 3));
    end
    tick(); clr(1);

    // Latency sweep, RD_LAT=3: alternating ch1/ch2 reads of distinct addresses.
    nret = 0;
    for (int i = 0; i < 8; i++) begin
      tick(); clr(1);
      set_ch(1, 1 + (i % 2), 1'b1, 1'b0, 15'(32'h40 + 3 * i), '0);
      @(negedge clk);
      if (i >= 3 && |rvalid_s[1]) nret++;
      if (i == 4) begin
        chk(1, "sweep_first_rv", 32'(rvalid_s[1]), 32'b010);
        chk(1, "sweep_first_rd", 32'(rdata_s[1]), 32'h5A1A);
      end
    end
    tick(); clr(1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (|rvalid_s[1]) nret++;
      tick();
    end
    chk(1, "sweep_returns", 32'(nret), 32'd8);

    // Mixed traffic on both instances over a small address window.
    for (int i = 0; i < 60; i++) begin
      tick();
      for (int d = 0; d < 2; d++)
        for (int c = 0; c < NCH; c++)
          set_ch(d, c, 1'($urandom_range(1)), 1'($urandom_range(1)),
                 15'($urandom_range(31)), 16'($urandom));
    end
    tick(); clr(0); clr(1);
    repeat (8) tick();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
